// File: rtl/glitc_clock_sequencer_if.sv
// Register-side and generator-side signals of the GLITC clock sequencer.
// The sequencer uses the slave modport; whoever drives requests and models the generator uses master.
interface glitc_clock_sequencer_if;
    logic        reconfig_req_i;
    logic        mult_sel_i;
    logic        mult_pwrdwn_i;
    logic        ps_req_i;
    logic [9:0]  ps_steps_i;
    logic        ps_dir_i;
    logic [2:0]  ctrl_o;
    logic [1:0]  status_i;
    logic [7:0]  phase_ctrl_o;
    logic [7:0]  phase_ctrl_i;
    logic        locked_o;
    logic        ps_busy_o;
    logic        ps_done_o;
    logic        ps_err_o;
    logic [15:0] ps_position_o;
    logic        lock_lost_o;
    logic        lock_timeout_o;

    modport slave (
        input  reconfig_req_i, mult_sel_i, mult_pwrdwn_i, ps_req_i, ps_steps_i, ps_dir_i,
        input  status_i, phase_ctrl_i,
        output ctrl_o, phase_ctrl_o, locked_o, ps_busy_o, ps_done_o, ps_err_o,
        output ps_position_o, lock_lost_o, lock_timeout_o
    );

    modport master (
        output reconfig_req_i, mult_sel_i, mult_pwrdwn_i, ps_req_i, ps_steps_i, ps_dir_i,
        output status_i, phase_ctrl_i,
        input  ctrl_o, phase_ctrl_o, locked_o, ps_busy_o, ps_done_o, ps_err_o,
        input  ps_position_o, lock_lost_o, lock_timeout_o
    );
endinterface

// File: rtl/glitc_clock_sequencer.sv
// Orders MMCM reset and lock acquisition, supervises lock, and runs multi-step
// PSEN/PSDONE phase moves while tracking the signed phase position.
module glitc_clock_sequencer #(
    parameter int unsigned RESET_CYCLES   = 16,
    parameter int unsigned LOCK_STABLE    = 8,
    parameter int unsigned LOCK_TIMEOUT   = 65535,
    parameter int unsigned PSDONE_TIMEOUT = 255,
    parameter logic        DEFAULT_SEL    = 1'b1
) (
    input logic                    clk_i,
    input logic                    rst_n_i,
    glitc_clock_sequencer_if.slave bus
);
    localparam int unsigned MAX_A = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned MAX_C = (MAX_A > PSDONE_TIMEOUT) ? MAX_A : PSDONE_TIMEOUT;
    localparam int CW = $clog2(MAX_C + 1);
    localparam int SW = $clog2(LOCK_STABLE + 1);

    typedef enum logic [2:0] {
        ST_RESET_ASSERT,
        ST_WAIT_LOCK,
        ST_IDLE,
        ST_PS_ISSUE,
        ST_PS_WAIT
    } state_t;

    state_t        state_reg;
    logic [CW-1:0] cnt_reg;
    logic [SW-1:0] stable_reg;
    logic [2:0]    ctrl_reg;
    logic          psen_reg;
    logic          psincdec_reg;
    logic [9:0]    steps_reg;
    logic          locked_reg;
    logic          busy_reg;
    logic          done_reg;
    logic          err_reg;
    logic [15:0]   position_reg;
    logic          lock_lost_reg;
    logic          lock_timeout_reg;

    logic [1:0]    lock_s;
    logic          required_lock;
    logic          psdone;
    logic          unused_bits;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;
            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    meta_reg <= 1'b0;
                    sync_reg <= 1'b0;
                end else begin
                    meta_reg <= bus.status_i[gi];
                    sync_reg <= meta_reg;
                end
            end
            assign lock_s[gi] = sync_reg;
        end
    endgenerate

    // The multiplier lock only matters while the multiplied input is selected.
    assign required_lock = lock_s[0] & (ctrl_reg[2] | lock_s[1]);
    assign psdone        = bus.phase_ctrl_i[0];
    assign unused_bits   = ^bus.phase_ctrl_i[7:1];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg        <= ST_RESET_ASSERT;
            cnt_reg          <= '0;
            stable_reg       <= '0;
            ctrl_reg         <= {DEFAULT_SEL, 1'b0, 1'b1};
            psen_reg         <= 1'b0;
            psincdec_reg     <= 1'b0;
            steps_reg        <= '0;
            locked_reg       <= 1'b0;
            busy_reg         <= 1'b0;
            done_reg         <= 1'b0;
            err_reg          <= 1'b0;
            position_reg     <= '0;
            lock_lost_reg    <= 1'b0;
            lock_timeout_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
            case (state_reg)
                ST_RESET_ASSERT: begin
                    if (cnt_reg == CW'(RESET_CYCLES - 1)) begin
                        state_reg   <= ST_WAIT_LOCK;
                        ctrl_reg[0] <= 1'b0;
                        cnt_reg     <= '0;
                        stable_reg  <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (required_lock && stable_reg == SW'(LOCK_STABLE - 1)) begin
                        state_reg    <= ST_IDLE;
                        locked_reg   <= 1'b1;
                        position_reg <= '0;
                    end else if (cnt_reg == CW'(LOCK_TIMEOUT - 1)) begin
                        lock_timeout_reg <= 1'b1;
                        state_reg        <= ST_RESET_ASSERT;
                        ctrl_reg[0]      <= 1'b1;
                        cnt_reg          <= '0;
                    end else begin
                        cnt_reg    <= cnt_reg + 1'b1;
                        stable_reg <= required_lock ? stable_reg + 1'b1 : '0;
                    end
                end
                ST_IDLE: begin
                    if (bus.reconfig_req_i) begin
                        // Never power the multiplier down while it is the selected input.
                        ctrl_reg         <= {bus.mult_sel_i, bus.mult_pwrdwn_i & bus.mult_sel_i, 1'b1};
                        lock_lost_reg    <= 1'b0;
                        lock_timeout_reg <= 1'b0;
                        locked_reg       <= 1'b0;
                        state_reg        <= ST_RESET_ASSERT;
                        cnt_reg          <= '0;
                    end else if (!required_lock) begin
                        lock_lost_reg <= 1'b1;
                        locked_reg    <= 1'b0;
                        ctrl_reg[0]   <= 1'b1;
                        state_reg     <= ST_RESET_ASSERT;
                        cnt_reg       <= '0;
                    end else if (bus.ps_req_i) begin
                        if (bus.ps_steps_i == '0) begin
                            done_reg <= 1'b1;
                        end else begin
                            steps_reg    <= bus.ps_steps_i;
                            psincdec_reg <= bus.ps_dir_i;
                            psen_reg     <= 1'b1;
                            busy_reg     <= 1'b1;
                            state_reg    <= ST_PS_ISSUE;
                        end
                    end
                end
                ST_PS_ISSUE, ST_PS_WAIT: begin
                    if (!required_lock) begin
                        lock_lost_reg <= 1'b1;
                        err_reg       <= 1'b1;
                        busy_reg      <= 1'b0;
                        psen_reg      <= 1'b0;
                        locked_reg    <= 1'b0;
                        ctrl_reg[0]   <= 1'b1;
                        state_reg     <= ST_RESET_ASSERT;
                        cnt_reg       <= '0;
                    end else if (state_reg == ST_PS_ISSUE) begin
                        // The PSEN cycle counts toward the PSDONE timeout.
                        psen_reg  <= 1'b0;
                        cnt_reg   <= CW'(1);
                        state_reg <= ST_PS_WAIT;
                    end else if (psdone) begin
                        position_reg <= psincdec_reg ? position_reg + 16'd1 : position_reg - 16'd1;
                        steps_reg    <= steps_reg - 10'd1;
                        if (steps_reg == 10'd1) begin
                            done_reg  <= 1'b1;
                            busy_reg  <= 1'b0;
                            state_reg <= ST_IDLE;
                        end else begin
                            psen_reg  <= 1'b1;
                            state_reg <= ST_PS_ISSUE;
                        end
                    end else if (cnt_reg == CW'(PSDONE_TIMEOUT - 1)) begin
                        err_reg     <= 1'b1;
                        busy_reg    <= 1'b0;
                        locked_reg  <= 1'b0;
                        ctrl_reg[0] <= 1'b1;
                        state_reg   <= ST_RESET_ASSERT;
                        cnt_reg     <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg   <= ST_RESET_ASSERT;
                    ctrl_reg[0] <= 1'b1;
                    cnt_reg     <= '0;
                end
            endcase
        end
    end

    assign bus.ctrl_o         = ctrl_reg;
    assign bus.phase_ctrl_o   = {6'b0, psincdec_reg, psen_reg};
    assign bus.locked_o       = locked_reg;
    assign bus.ps_busy_o      = busy_reg;
    assign bus.ps_done_o      = done_reg;
    assign bus.ps_err_o       = err_reg;
    assign bus.ps_position_o  = position_reg;
    assign bus.lock_lost_o    = lock_lost_reg;
    assign bus.lock_timeout_o = lock_timeout_reg;
endmodule

// File: tb/tb_glitc_clock_sequencer.sv
// Directed bench for glitc_clock_sequencer: table of phase moves plus hand-written
// sequences for reset, reconfiguration, lock loss and lock timeout.
module tb_glitc_clock_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    glitc_clock_sequencer_if bus();

    glitc_clock_sequencer dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int steps;
        bit dir;
        int delay;     // PSDONE delay after PSEN, -1 = withheld
        int drop_at;   // cycle at which status_i[0] drops, -1 = never
        int pulses;
        int gap;
        int dones;
        int errs;
        int end_cyc;
        int busy0;
        int incdec;
        int pos;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_locked(input int bound, output int n);
        n = -1;
        for (int k = 1; k <= bound; k++) begin
            @(negedge clk);
            if (bus.locked_o) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic run_move(input int steps, input bit dir, input int delay, input int drop_at,
                            output int pulses, output int gap, output int dones, output int errs,
                            output int end_cyc, output int busy0, output int busy_end,
                            output int incdec, output int pos);
        int last;
        int due;
        pulses = 0; gap = -1; dones = 0; errs = 0; end_cyc = -1;
        busy0 = 0; busy_end = -1; incdec = -1; pos = -1; last = -1; due = -1;
        @(posedge clk); #1;
        bus.ps_req_i   = 1'b1;
        bus.ps_steps_i = 10'(steps);
        bus.ps_dir_i   = dir;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(posedge clk); #1;
            bus.ps_req_i     = 1'b0;
            bus.phase_ctrl_i = {7'b0, (cyc == due)};
            if (cyc == drop_at) bus.status_i[0] = 1'b0;
            @(negedge clk);
            if (cyc == 0) busy0 = int'(bus.ps_busy_o);
            if (bus.phase_ctrl_o[0]) begin
                pulses++;
                if (last >= 0) gap = cyc - last;
                if (incdec < 0) incdec = int'(bus.phase_ctrl_o[1]);
                last = cyc;
                if (delay >= 0) due = cyc + delay;
            end
            if (bus.ps_done_o) dones++;
            if (bus.ps_err_o) errs++;
            if ((bus.ps_done_o || bus.ps_err_o) && end_cyc < 0) begin
                end_cyc  = cyc;
                pos      = int'(bus.ps_position_o);
                busy_end = int'(bus.ps_busy_o);
            end
            if (end_cyc >= 0 && cyc >= end_cyc + 3) break;
        end
        bus.phase_ctrl_i = '0;
    endtask

    initial begin
        int n;
        int pulses, gap, dones, errs, end_cyc, busy0, busy_end, incdec, pos;

        bus.reconfig_req_i = 1'b0;
        bus.mult_sel_i     = 1'b0;
        bus.mult_pwrdwn_i  = 1'b0;
        bus.ps_req_i       = 1'b0;
        bus.ps_steps_i     = '0;
        bus.ps_dir_i       = 1'b0;
        bus.status_i       = 2'b00;
        bus.phase_ctrl_i   = '0;

        //            steps dir dly drop pls gap dn er end busy0 incdec pos
        vecs[0] = '{3, 1'b1, 12, -1, 3, 13, 1, 0,  39, 1,  1, 3};
        vecs[1] = '{5, 1'b0, 12, -1, 5, 13, 1, 0,  65, 1,  0, 'hFFFE};
        vecs[2] = '{0, 1'b1, 12, -1, 0, -1, 1, 0,   0, 0, -1, 'hFFFE};
        vecs[3] = '{2, 1'b0, -1, -1, 1, -1, 0, 1, 255, 1,  0, 'hFFFE};
        vecs[4] = '{3, 1'b1, 12, 20, 2, 13, 0, 1,  23, 1,  1, 1};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ctrl", int'(bus.ctrl_o), 5);
        check("rst_phase_ctrl", int'(bus.phase_ctrl_o), 0);
        check("rst_position", int'(bus.ps_position_o), 0);
        check("rst_flags", int'({bus.locked_o, bus.ps_busy_o, bus.ps_done_o, bus.ps_err_o,
                                 bus.lock_lost_o, bus.lock_timeout_o}), 0);

        @(posedge clk); #1;
        rst_n = 1'b1;
        n = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.ctrl_o[0]) n++;
            else break;
        end
        check("reset_pulse_len", n, 16);
        $display("reset released: ctrl_o[0] high for %0d cycles", n);

        repeat (5) @(posedge clk);
        @(negedge clk);
        bus.status_i[0] = 1'b1;
        wait_locked(50, n);
        check("lock_latency", n, 10);
        check("ctrl_after_lock", int'(bus.ctrl_o), 4);
        $display("locked after %0d cycles, ctrl_o=%b", n, bus.ctrl_o);

        // Phase moves
        for (int i = 0; i < 5; i++) begin
            wait_locked(200, n);
            check("pre_move_locked", int'(n > 0), 1);
            if (i > 0 && vecs[i-1].errs != 0) check("pos_cleared", int'(bus.ps_position_o), 0);
            run_move(vecs[i].steps, vecs[i].dir, vecs[i].delay, vecs[i].drop_at,
                     pulses, gap, dones, errs, end_cyc, busy0, busy_end, incdec, pos);
            $display("move %0d: steps=%0d dir=%0d pulses=%0d gap=%0d done=%0d err=%0d end=%0d pos=%h",
                     i, vecs[i].steps, vecs[i].dir, pulses, gap, dones, errs, end_cyc, pos[15:0]);
            check("psen_pulses", pulses, vecs[i].pulses);
            check("psen_gap", gap, vecs[i].gap);
            check("done_count", dones, vecs[i].dones);
            check("err_count", errs, vecs[i].errs);
            check("end_cycle", end_cyc, vecs[i].end_cyc);
            check("busy_rise", busy0, vecs[i].busy0);
            check("busy_fall", busy_end, 0);
            check("psincdec", incdec, vecs[i].incdec);
            check("position", pos, vecs[i].pos);
            if (vecs[i].errs != 0) check("reset_reasserted", int'(bus.ctrl_o[0]), 1);
        end

        // Lock loss mid-move left the sticky flag set and no relock while status is low
        check("lock_lost_set", int'(bus.lock_lost_o), 1);
        repeat (40) @(negedge clk);
        check("no_relock_without_status", int'(bus.locked_o), 0);
        bus.status_i[0] = 1'b1;
        wait_locked(100, n);
        check("relock_after_loss", int'(n > 0), 1);

        // Reconfig to multiplied input, with a simultaneous phase request that must be dropped
        @(posedge clk); #1;
        bus.reconfig_req_i = 1'b1;
        bus.mult_sel_i     = 1'b0;
        bus.mult_pwrdwn_i  = 1'b1;
        bus.ps_req_i       = 1'b1;
        bus.ps_steps_i     = 10'd2;
        @(posedge clk); #1;
        bus.reconfig_req_i = 1'b0;
        bus.ps_req_i       = 1'b0;
        @(negedge clk);
        check("lock_lost_cleared", int'(bus.lock_lost_o), 0);
        check("reconfig_ctrl", int'(bus.ctrl_o), 1);
        check("reconfig_drops_ps", int'({bus.ps_busy_o, bus.phase_ctrl_o[0]}), 0);
        n = -1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!bus.ctrl_o[0]) begin n = k; break; end
        end
        check("reconfig_reset_ends", int'(n >= 0), 1);
        check("mult_ctrl", int'(bus.ctrl_o), 0);
        wait_locked(100, n);
        check("no_lock_without_mult", n, -1);
        bus.status_i[1] = 1'b1;
        wait_locked(50, n);
        check("mult_lock_latency", n, 10);
        $display("reconfig sel=0: ctrl_o=%b locked after %0d cycles", bus.ctrl_o, n);

        // Lock never arrives: timeout and retry
        @(posedge clk); #1;
        bus.reconfig_req_i = 1'b1;
        bus.mult_sel_i     = 1'b1;
        bus.mult_pwrdwn_i  = 1'b1;
        bus.status_i       = 2'b00;
        @(posedge clk); #1;
        bus.reconfig_req_i = 1'b0;
        n = -1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!bus.ctrl_o[0]) begin n = k; break; end
        end
        check("timeout_reset_ends", int'(n >= 0), 1);
        check("pwrdwn_ctrl", int'(bus.ctrl_o), 6);
        n = -1;
        for (int k = 1; k <= 70000; k++) begin
            @(negedge clk);
            if (bus.lock_timeout_o) begin n = k; break; end
        end
        check("lock_timeout_cycles", n, 65535);
        check("retry_reset", int'(bus.ctrl_o[0]), 1);
        check("no_lost_on_timeout", int'(bus.lock_lost_o), 0);
        $display("lock timeout after %0d cycles in WAIT_LOCK", n);
        n = 1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.ctrl_o[0]) n++;
            else break;
        end
        check("retry_pulse_len", n, 16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
